saturate: RTL and testbench
===========================

SATURATE -- requirements
Module: saturate

Interface
REQ-001 Parameter IN_W, default 10, width of the unsigned input operand.
REQ-002 Parameter OUT_W, default 8, width of the clamped output; IN_W > OUT_W is required.
REQ-003 Parameter CNT_W, default 16, width of the saturation event counter.
REQ-004 clk  input  1  clock; all registers update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  sample enable for the registered outputs and statistics.
REQ-007 clr_stats  input  1  synchronous clear of sat_cnt and sat_sticky.
REQ-008 din  input  IN_W  unsigned value to clamp.
REQ-009 dout  output  OUT_W  combinational clamped value.
REQ-010 sat  output  1  combinational flag; din exceeds the OUT_W range.
REQ-011 dout_q  output  OUT_W  registered dout.
REQ-012 sat_q  output  1  registered sat.
REQ-013 sat_cnt  output  CNT_W  count of enabled cycles with sat=1.
REQ-014 sat_sticky  output  1  set once any enabled cycle has sat=1.

Function
REQ-015 din is unsigned; MAXV = 2^OUT_W-1 (255 at default).
REQ-016 sat = 1 iff din > MAXV, i.e. any of din[IN_W-1:OUT_W] is nonzero.
REQ-017 dout = MAXV when sat=1, else din[OUT_W-1:0].
REQ-018 dout and sat have zero latency and do not depend on clk, rst or en.
REQ-019 Values 0..MAXV pass unchanged; there is no lower clamp.
REQ-020 On a rising edge with rst=0 and en=1: dout_q <= dout and sat_q <= sat, giving 1-cycle latency.
REQ-021 With en=0, dout_q and sat_q hold.
REQ-022 sat_cnt increments by 1 on each edge with rst=0, en=1, sat=1 and clr_stats=0.
REQ-023 sat_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-024 sat_sticky sets on an edge with rst=0, en=1, sat=1 and clr_stats=0, and holds until cleared.
REQ-025 clr_stats=1 with rst=0 zeroes sat_cnt and sat_sticky on that edge, overriding a simultaneous increment or set.
REQ-026 clr_stats does not affect dout_q or sat_q.

Reset
REQ-027 rst=1 on a rising edge sets dout_q=0, sat_q=0, sat_cnt=0 and sat_sticky=0, overriding en and clr_stats.
REQ-028 Reset affects only registered outputs; dout and sat keep tracking din during reset.
REQ-029 The first enabled edge after rst deasserts samples normally, with no extra flush cycle.

Verification
REQ-030 Set din=0, 128, 255 in turn -> dout=0, 128, 255 with sat=0; one cycle later (en=1), dout_q matches and sat_q=0.
REQ-031 Set din=256, 366, 1023 in turn -> dout=255 with sat=1 combinationally; one enabled cycle later, dout_q=255 and sat_q=1.
REQ-032 Run 3 enabled cycles with din=300, then 2 cycles with din=100 -> sat_cnt=3, sat_sticky=1; then pulse clr_stats while din=300 -> sat_cnt=0, sat_sticky=0.
REQ-033 Hold en=0 with din=500 for 4 cycles -> dout=255 and sat=1, while dout_q, sat_q and sat_cnt hold their prior values.
REQ-034 Assert rst during din=400, en=1 -> on the edge, dout_q=0, sat_q=0, sat_cnt=0 and sat_sticky=0, while dout=255 throughout.
REQ-035 With CNT_W=2, run 6 enabled cycles with din=512 -> sat_cnt stops at 3.

Source files
------------

// File: rtl/saturate.sv
// Unsigned clamp of an IN_W-bit value into OUT_W bits, with a registered copy of the
// result and saturation statistics (event counter plus sticky flag).
module saturate #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_stats,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat,
  output logic [OUT_W-1:0] dout_q,
  output logic             sat_q,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             sat_sticky
);

  localparam logic [OUT_W-1:0] MaxV   = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [OUT_W-1:0] dout_d;
  logic             sat_d;
  logic [CNT_W-1:0] sat_cnt_d;
  logic             sat_sticky_d;

  // Combinational clamp: any set bit above the output range forces full scale.
  always_comb begin
    sat  = |din[IN_W-1:OUT_W];
    dout = sat ? MaxV : din[OUT_W-1:0];
  end

  // Next-state for the registered copy and the statistics; clear beats increment.
  always_comb begin
    dout_d       = dout_q;
    sat_d        = sat_q;
    sat_cnt_d    = sat_cnt;
    sat_sticky_d = sat_sticky;
    if (en) begin
      dout_d = dout;
      sat_d  = sat;
    end
    if (clr_stats) begin
      sat_cnt_d    = '0;
      sat_sticky_d = 1'b0;
    end else if (en && sat) begin
      sat_sticky_d = 1'b1;
      // Counter pins at all-ones instead of wrapping.
      if (sat_cnt != CntMax) begin
        sat_cnt_d = sat_cnt + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      sat_q      <= 1'b0;
      sat_cnt    <= '0;
      sat_sticky <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      sat_q      <= sat_d;
      sat_cnt    <= sat_cnt_d;
      sat_sticky <= sat_sticky_d;
    end
  end

endmodule

// File: tb/tb_saturate.sv
// Self-checking bench for saturate: directed scenarios followed by random traffic, checked
// against an arithmetic reference model. A second instance with a 2-bit counter exercises
// counter saturation.
module tb_saturate;

  localparam int MAXV   = (1 << 8) - 1;
  localparam int CMAX16 = (1 << 16) - 1;
  localparam int CMAX2  = (1 << 2) - 1;

  logic       clk = 1'b0;
  logic       rst, en, clr_stats;
  logic [9:0] din;

  logic [7:0]  dout, dout_q, dout2, dout_q2;
  logic        sat, sat_q, sat_sticky, sat2, sat_q2, sat_sticky2;
  logic [15:0] sat_cnt;
  logic [1:0]  sat_cnt2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_dout_q, m_sat_q, m_cnt, m_cnt2, m_sticky;

  always #5 clk = ~clk;

  saturate #(.IN_W(10), .OUT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats), .din(din),
    .dout(dout), .sat(sat), .dout_q(dout_q), .sat_q(sat_q),
    .sat_cnt(sat_cnt), .sat_sticky(sat_sticky)
  );

  saturate #(.IN_W(10), .OUT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr_stats(clr_stats), .din(din),
    .dout(dout2), .sat(sat2), .dout_q(dout_q2), .sat_q(sat_q2),
    .sat_cnt(sat_cnt2), .sat_sticky(sat_sticky2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic check_comb();
    chk("dout", int'(dout), clamp(int'(din)));
    chk("sat", int'(sat), (int'(din) > MAXV) ? 1 : 0);
  endtask

  task automatic check_all();
    check_comb();
    chk("dout_q", int'(dout_q), m_dout_q);
    chk("sat_q", int'(sat_q), m_sat_q);
    chk("sat_cnt", int'(sat_cnt), m_cnt);
    chk("sat_sticky", int'(sat_sticky), m_sticky);
    chk("sat_cnt_w2", int'(sat_cnt2), m_cnt2);
    chk("sat_sticky_w2", int'(sat_sticky2), m_sticky);
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    int v;
    v = int'(din);
    if (rst) begin
      m_dout_q = 0; m_sat_q = 0; m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
    end else begin
      if (en) begin
        m_dout_q = clamp(v);
        m_sat_q  = (v > MAXV) ? 1 : 0;
      end
      if (clr_stats) begin
        m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
      end else if (en && v > MAXV) begin
        m_sticky = 1;
        if (m_cnt < CMAX16) m_cnt++;
        if (m_cnt2 < CMAX2) m_cnt2++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int vals_lo[3] = '{0, 128, 255};
    int vals_hi[3] = '{256, 366, 1023};

    rst = 1'b1; en = 1'b0; clr_stats = 1'b0; din = '0;
    m_dout_q = 0; m_sat_q = 0; m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
    tick();
    tick();
    rst = 1'b0;

    // In-range values pass through unchanged
    en = 1'b1;
    foreach (vals_lo[i]) begin
      din = 10'(vals_lo[i]);
      #1 check_comb();
      tick();
    end

    // Out-of-range values clamp to full scale
    foreach (vals_hi[i]) begin
      din = 10'(vals_hi[i]);
      #1 check_comb();
      tick();
    end

    // Statistics: clear, then 3 saturating + 2 in-range cycles, then clear while saturating
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    din = 10'd300;
    repeat (3) tick();
    din = 10'd100;
    repeat (2) tick();
    chk("cnt_after_3", int'(sat_cnt), 3);
    din = 10'd300; clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("cnt_after_clr", int'(sat_cnt), 0);

    // Disabled cycles hold registered outputs while the clamp keeps tracking
    din = 10'd50; tick();
    en = 1'b0; din = 10'd500;
    repeat (4) tick();
    chk("hold_dout_q", int'(dout_q), 50);

    // Reset overrides enable
    en = 1'b1; din = 10'd300; repeat (2) tick();
    din = 10'd400; rst = 1'b1; tick();
    rst = 1'b0;
    tick();

    // Narrow counter stops at its maximum
    din = 10'd512;
    repeat (6) tick();
    chk("cnt2_sat", int'(sat_cnt2), 3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      din       = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 255))
                                              : 10'($urandom_range(256, 1023));
      en        = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
